// File: rtl/mem_responder.sv
// Memory-side responder: word-organised RAM window with byte strobes,
// programmable read/write wait states and out-of-window fault flagging.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned READ_WAIT   = 1,
  parameter int unsigned WRITE_WAIT  = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        access_fault,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          fault_q, fault_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] reqIdx;
  logic          reqFault;
  logic [3:0]    reqCnt;
  logic          unusedAddrLsb;

  // Unsigned subtraction makes addresses below the base wrap high and fault too.
  assign offset        = mem_addr - BASE_ADDR;
  assign reqIdx        = offset[AW+1:2];
  assign reqFault      = ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
  assign reqCnt        = (mem_wstrb != 4'b0000) ? 4'(WRITE_WAIT) : 4'(READ_WAIT);
  assign unusedAddrLsb = ^offset[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          idx_d   = reqIdx;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          fault_d = reqFault;
          cnt_d   = reqCnt;
          if (reqCnt != 4'd0) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            if (mem_wstrb == 4'b0000) begin
              rdata_d = reqFault ? 32'h0 : mem[reqIdx];
            end
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          if (wstrb_q == 4'b0000) begin
            rdata_d = fault_q ? 32'h0 : mem[idx_q];
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  // Commit happens on the edge leaving RESP; a reset during WAIT/RESP forces IDLE first.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wstrb_q != 4'b0000 && !fault_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign mem_ready    = (state_q == RESP);
  assign access_fault = (state_q == RESP) && fault_q;
  assign busy         = (state_q != IDLE);
  assign mem_rdata    = rdata_q;

endmodule
